// File: rtl/fp_mul_issuer_if.sv
// Connection bundle between the issuer, its operand/result memories,
// the float unit and the enclosing control. The issuer takes the
// master side; everything it talks to sits on the slave side.
interface fp_mul_issuer_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 4
);
   // control handshake
   logic              go;
   logic              done;
   // operand memories (combinational read)
   logic [ADDR_W-1:0] a_addr0;
   logic [ADDR_W-1:0] b_addr0;
   logic [WIDTH-1:0]  a_read_data;
   logic [WIDTH-1:0]  b_read_data;
   // float unit go/done
   logic              unit_go;
   logic [WIDTH-1:0]  unit_left;
   logic [WIDTH-1:0]  unit_right;
   logic [WIDTH-1:0]  unit_out;
   logic [4:0]        unit_flags;
   logic              unit_done;
   // result memory write port
   logic [ADDR_W-1:0] out_addr0;
   logic [WIDTH-1:0]  out_write_data;
   logic              out_write_en;
   // sticky exception flags
   logic [4:0]        flags_acc;

   modport master (
      input  go, a_read_data, b_read_data, unit_out, unit_flags, unit_done,
      output done, a_addr0, b_addr0, unit_go, unit_left, unit_right,
             out_addr0, out_write_data, out_write_en, flags_acc
   );

   modport slave (
      output go, a_read_data, b_read_data, unit_out, unit_flags, unit_done,
      input  done, a_addr0, b_addr0, unit_go, unit_left, unit_right,
             out_addr0, out_write_data, out_write_en, flags_acc
   );
endinterface

// File: rtl/fp_mul_issuer.sv
// Streams LEN operand pairs through a multi-cycle float unit using the
// go/done handshake, writes each result back and keeps sticky flags.
// Every element goes FETCH -> ISSUE -> WRITE -> DRAIN; DRAIN waits for
// unit_done to drop so a lingering done from the previous element can
// never be mistaken for completion of the next one.
module fp_mul_issuer #(
   parameter int WIDTH  = 32,
   parameter int LEN    = 16,
   parameter int ADDR_W = 4
) (
   input  logic           clk,
   input  logic           reset,
   fp_mul_issuer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      ISSUE = 3'd2,
      WRITE = 3'd3,
      DRAIN = 3'd4,
      FIN   = 3'd5
   } state_t;

   // index of the final element; idx stops here and never wraps
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LEN - 1);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] idx;
   logic [WIDTH-1:0]  left;
   logic [WIDTH-1:0]  right;
   logic [WIDTH-1:0]  result;
   logic [4:0]        flags;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // next state and state-decoded strobes (all zero while in reset via IDLE)
   always_comb begin
      state_next       = state;
      bus.unit_go      = 1'b0;
      bus.out_write_en = 1'b0;
      bus.done         = 1'b0;
      case (state)
         IDLE:  if (bus.go) state_next = FETCH;
         FETCH: state_next = ISSUE;
         ISSUE: begin
            bus.unit_go = 1'b1;
            if (bus.unit_done) state_next = WRITE;
         end
         WRITE: begin
            bus.out_write_en = 1'b1;
            state_next       = DRAIN;
         end
         DRAIN: if (!bus.unit_done) state_next = (idx == LAST_IDX) ? FIN : FETCH;
         FIN: begin
            bus.done   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // element index, operand latches, result latch and sticky flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx    <= '0;
         left   <= '0;
         right  <= '0;
         result <= '0;
         flags  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.go) begin
               idx   <= '0;
               flags <= '0;
            end
            FETCH: begin
               left  <= bus.a_read_data;
               right <= bus.b_read_data;
            end
            ISSUE: if (bus.unit_done) begin
               result <= bus.unit_out;
               flags  <= flags | bus.unit_flags;
            end
            DRAIN: if (!bus.unit_done && idx != LAST_IDX) idx <= idx + 1'b1;
            FIN:   idx <= '0;
            default: ;
         endcase
      end
   end

   // operand and result addresses all follow the element index
   assign bus.a_addr0        = idx;
   assign bus.b_addr0        = idx;
   assign bus.out_addr0      = idx;
   assign bus.unit_left      = left;
   assign bus.unit_right     = right;
   assign bus.out_write_data = result;
   assign bus.flags_acc      = flags;

endmodule

// File: tb/tb_fp_mul_issuer.sv
// Directed bench for fp_mul_issuer: a LAT-deep go/done unit model that
// doubles its left operand (exponent+1) and yields NaN/invalid for inf*0,
// run timing and result checks, flag clearing, a long-done unit, mid-run
// reset, go held across a run, and a LEN=1 instance.
module tb_fp_mul_issuer;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_mul_issuer_if #(.WIDTH(32), .ADDR_W(4)) bus ();
   fp_mul_issuer_if #(.WIDTH(32), .ADDR_W(4)) bus1 ();

   fp_mul_issuer #(.WIDTH(32), .LEN(16), .ADDR_W(4)) dut (
      .clk(clk), .reset(rst_n), .bus(bus));
   fp_mul_issuer #(.WIDTH(32), .LEN(1), .ADDR_W(4)) dut1 (
      .clk(clk), .reset(rst_n), .bus(bus1));

   logic [31:0] a_mem [16];
   logic [31:0] b_mem [16];
   assign bus.a_read_data  = a_mem[bus.a_addr0];
   assign bus.b_read_data  = b_mem[bus.b_addr0];
   assign bus1.a_read_data = a_mem[bus1.a_addr0];
   assign bus1.b_read_data = b_mem[bus1.b_addr0];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // unit models: done = go delayed LAT cycles, optionally stretched by 'extra'
   int          extra = 0;
   logic [15:0] go_sr = '0;
   logic [15:0] go_sr1 = '0;
   always @(posedge clk) go_sr  <= {go_sr[14:0], bus.unit_go};
   always @(posedge clk) go_sr1 <= {go_sr1[14:0], bus1.unit_go};

   always_comb begin
      bus.unit_done = 1'b0;
      for (int k = 0; k < 16; k++)
         if (k >= LAT - 1 && k <= LAT - 1 + extra && go_sr[k]) bus.unit_done = 1'b1;
      bus1.unit_done = go_sr1[LAT-1];
   end

   always_comb begin
      if (bus.unit_left[30:0] == 31'h7F800000 && bus.unit_right[30:0] == 31'h0) begin
         bus.unit_out   = 32'h7FC00000;
         bus.unit_flags = 5'b10000;
      end else begin
         bus.unit_out   = bus.unit_left + 32'h00800000;
         bus.unit_flags = 5'b00000;
      end
      bus1.unit_out   = bus1.unit_left + 32'h00800000;
      bus1.unit_flags = 5'b00000;
   end

   // monitor: logs every write and done pulse with its absolute cycle
   int          n_wr = 0, n_done = 0, consec = 0, issue_bad = 0;
   logic [3:0]  wr_addr [256];
   logic [31:0] wr_data [256];
   int          wr_cyc  [256];
   int          done_log [64];
   logic        prev_we = 1'b0, prev_ugo = 1'b0;
   int          n_wr1 = 0, n_done1 = 0, done1_cyc = 0;
   logic [31:0] wr1_data = '0;
   logic [3:0]  wr1_addr = '0;

   always @(negedge clk) begin
      if (bus.out_write_en) begin
         if (n_wr < 256) begin
            wr_addr[n_wr] <= bus.out_addr0;
            wr_data[n_wr] <= bus.out_write_data;
            wr_cyc[n_wr]  <= cyc;
         end
         n_wr <= n_wr + 1;
         if (prev_we) consec <= consec + 1;
      end
      prev_we <= bus.out_write_en;
      if (bus.done) begin
         if (n_done < 64) done_log[n_done] <= cyc;
         n_done <= n_done + 1;
      end
      if (bus.unit_go && !prev_ugo && bus.unit_done) issue_bad <= issue_bad + 1;
      prev_ugo <= bus.unit_go;
      if (bus1.out_write_en) begin
         wr1_data <= bus1.out_write_data;
         wr1_addr <= bus1.out_addr0;
         n_wr1    <= n_wr1 + 1;
      end
      if (bus1.done) begin
         done1_cyc <= cyc;
         n_done1   <= n_done1 + 1;
      end
   end

   int n_checks = 0, n_fail = 0;
   int c0 = 0, wb = 0, db = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] int_to_float(input int n);
      int p = 0;
      for (int k = 0; k < 31; k++) if (((n >> k) & 1) == 1) p = k;
      return {1'b0, 8'(127 + p), 23'((n << (23 - p)) & 32'h007FFFFF)};
   endfunction

   // go high in cycle 0 and for 'hold' cycles in total; returns at cycle 'hold'
   task automatic start_run(input int hold);
      @(negedge clk);
      bus.go = 1'b1;
      c0 = cyc; wb = n_wr; db = n_done;
      repeat (hold) @(negedge clk);
      bus.go = 1'b0;
   endtask

   task automatic wait_done(input int cnt, input int limit);
      int t = 0;
      while (n_done - db < cnt && t < limit) begin
         @(negedge clk);
         t++;
      end
      check("done_timeout", 32'(t < limit), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_run(input int cs, input int wb0, input int per, input int nan_idx);
      for (int i = 0; i < 16; i++) begin
         int k = wb0 + i;
         check($sformatf("wr%0d_addr", i), 32'(wr_addr[k]), 32'(i));
         check($sformatf("wr%0d_cycle", i), wr_cyc[k], cs + 1 + i * per + LAT + 2);
         if (i == nan_idx)
            check($sformatf("wr%0d_nan", i),
                  32'(wr_data[k][30:23] == 8'hFF && wr_data[k][22:0] != 23'd0), 32'd1);
         else
            check($sformatf("wr%0d_data", i), wr_data[k], int_to_float(2 * (i + 1)));
      end
   endtask

   initial begin
      bus.go  = 1'b0;
      bus1.go = 1'b0;
      for (int i = 0; i < 16; i++) begin
         a_mem[i] = int_to_float(i + 1);
         b_mem[i] = 32'h40000000;
      end

      // reset values
      repeat (3) @(negedge clk);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_unit_go", 32'(bus.unit_go), 32'd0);
      check("rst_we", 32'(bus.out_write_en), 32'd0);
      check("rst_flags", 32'(bus.flags_acc), 32'd0);
      check("rst_a_addr", 32'(bus.a_addr0), 32'd0);
      check("rst_wdata", bus.out_write_data, 32'd0);
      check("rst_left", bus.unit_left, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // basic run: out[i] = 2(i+1), 11-cycle elements, done in cycle 177
      start_run(1);
      wait_done(1, 400);
      check("basic_done_cycle", done_log[db], c0 + 177);
      check("basic_done_count", n_done - db, 1);
      check("basic_wr_count", n_wr - wb, 16);
      check_run(c0, wb, 11, -1);
      check("basic_w0", wr_data[wb], 32'h40000000);
      check("basic_w15", wr_data[wb+15], 32'h42000000);
      check("basic_flags", 32'(bus.flags_acc), 32'd0);

      // inf * 0 on element 3 gives NaN and a sticky invalid flag
      a_mem[3] = 32'h7F800000;
      b_mem[3] = 32'h00000000;
      start_run(1);
      wait_done(1, 400);
      check_run(c0, wb, 11, 3);
      check("nan_flags", 32'(bus.flags_acc), 32'h10);

      // clean run clears flags on go
      a_mem[3] = int_to_float(4);
      b_mem[3] = 32'h40000000;
      start_run(1);
      check("flags_cleared", 32'(bus.flags_acc), 32'd0);
      wait_done(1, 400);
      check_run(c0, wb, 11, -1);
      check("clean_flags", 32'(bus.flags_acc), 32'd0);

      // unit holds done 6 extra cycles: DRAIN grows by 6 per element
      extra = 6;
      start_run(1);
      wait_done(1, 600);
      check("long_done_cycle", done_log[db], c0 + 1 + 16 * 17);
      check_run(c0, wb, 17, -1);
      check("long_issue_while_done", issue_bad, 0);
      extra = 0;
      repeat (12) @(negedge clk);

      // go held through the run and one cycle past done: back-to-back runs
      start_run(179);
      wait_done(2, 400);
      check("hold_done1", done_log[db], c0 + 177);
      check("hold_done2", done_log[db+1], c0 + 178 + 177);
      check("hold_wr_count", n_wr - wb, 32);
      check_run(c0, wb, 11, -1);
      check_run(c0 + 178, wb + 16, 11, -1);

      // reset mid-ISSUE of element 3
      start_run(1);
      repeat (36) @(negedge clk);
      check("pre_rst_unit_go", 32'(bus.unit_go), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_unit_go", 32'(bus.unit_go), 32'd0);
      check("arst_we", 32'(bus.out_write_en), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      check("arst_addr", 32'(bus.a_addr0), 32'd0);
      check("arst_left", bus.unit_left, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("arst_writes", n_wr - wb, 3);
      check("arst_no_done", n_done - db, 0);
      start_run(1);
      wait_done(1, 400);
      check("after_rst_done", done_log[db], c0 + 177);
      check("after_rst_wr_count", n_wr - wb, 16);
      check_run(c0, wb, 11, -1);
      check("consecutive_writes", consec, 0);

      // LEN=1 instance: done in cycle 12
      @(negedge clk);
      bus1.go = 1'b1;
      c0 = cyc;
      @(negedge clk);
      bus1.go = 1'b0;
      for (int t = 0; t < 60 && n_done1 == 0; t++) @(negedge clk);
      check("len1_done_count", n_done1, 1);
      check("len1_done_cycle", done1_cyc, c0 + 12);
      check("len1_wr_count", n_wr1, 1);
      check("len1_wr_addr", 32'(wr1_addr), 32'd0);
      check("len1_wr_data", wr1_data, 32'h40000000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
